// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter sharing one 2-stage signed 8x8 multiplier among NREQ requesters.
// Results are tagged with the issuing lane and returned in issue order through a credit-guarded FIFO.

module signed_mult (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] prod
);
    logic signed [7:0]  a_reg;
    logic signed [7:0]  b_reg;
    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;
    logic signed [15:0] prod_reg;

    assign a_ext = a_reg;
    assign b_ext = b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            prod_reg <= '0;
        end else begin
            a_reg    <= a;
            b_reg    <= b;
            prod_reg <= a_ext * b_ext;
        end
    end

    assign prod = prod_reg;
endmodule

module signed_mult_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int RSP_DEPTH = 4,
    localparam int ID_W      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic signed [15:0]  rsp_prod,
    output logic                busy
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int USE_W = CNT_W + 1;
    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NREQ);

    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [ID_W-1:0]    cand_idx [NREQ];
    logic [NREQ-1:0]    cand_vld;
    logic signed [7:0]  lane_a [NREQ];
    logic signed [7:0]  lane_b [NREQ];
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic               credit_ok;
    logic               issue;

    logic               tag1_vld_reg;
    logic [ID_W-1:0]    tag1_id_reg;
    logic               tag2_vld_reg;
    logic [ID_W-1:0]    tag2_id_reg;
    logic signed [15:0] mult_prod;
    logic [1:0]         inflight;
    logic [USE_W-1:0]   used;

    logic signed [15:0] mem_prod [RSP_DEPTH];
    logic [ID_W-1:0]    mem_id   [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   fifo_count_reg;
    logic               push;
    logic               pop;

    // cand_idx[k] is the lane examined k-th, starting from rr_ptr and wrapping
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            logic [ID_W:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + (ID_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= NREQ_W) ? ID_W'(sum - NREQ_W) : sum[ID_W-1:0];
            assign cand_vld[gi] = req_valid[cand_idx[gi]];
            assign lane_a[gi]   = req_a[8*gi +: 8];
            assign lane_b[gi]   = req_b[8*gi +: 8];
            assign req_ready[gi] = issue && (grant_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign inflight  = {1'b0, tag1_vld_reg} + {1'b0, tag2_vld_reg};
    assign used      = USE_W'(fifo_count_reg) + USE_W'(inflight);
    assign credit_ok = used < USE_W'(RSP_DEPTH);
    // Gating with rst_n keeps req_ready low for the whole time reset is asserted
    assign issue     = grant_found && credit_ok && rst_n;

    assign rr_ptr_next = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            tag1_vld_reg <= 1'b0;
            tag1_id_reg  <= '0;
            tag2_vld_reg <= 1'b0;
            tag2_id_reg  <= '0;
        end else begin
            if (issue) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            tag1_vld_reg <= issue;
            tag1_id_reg  <= grant_idx;
            tag2_vld_reg <= tag1_vld_reg;
            tag2_id_reg  <= tag1_id_reg;
        end
    end

    // Operands of the current grant always feed the pipe; only tagged slots reach the FIFO
    signed_mult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (lane_a[grant_idx]),
        .b     (lane_b[grant_idx]),
        .prod  (mult_prod)
    );

    assign push = tag2_vld_reg;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_prod[wr_ptr_reg] <= mult_prod;
            mem_id[wr_ptr_reg]   <= tag2_id_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                fifo_count_reg <= fifo_count_reg + 1'b1;
            end else if (pop && !push) begin
                fifo_count_reg <= fifo_count_reg - 1'b1;
            end
        end
    end

    assign rsp_valid = (fifo_count_reg != '0);
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr_reg] : '0;
    assign rsp_prod  = rsp_valid ? mem_prod[rd_ptr_reg] : '0;
    assign busy      = (inflight != 2'd0) || rsp_valid;
endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Bench for signed_mult_arbiter: table vectors, directed corner sequences and random traffic,
// all checked against a queue-based model of outstanding operations.

module tb_signed_mult_arbiter;
    localparam int NREQ  = 4;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic [3:0]         req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [15:0]        rsp_prod;
    logic               busy;

    logic signed [7:0]  op_a [4];
    logic signed [7:0]  op_b [4];

    signed_mult_arbiter #(.NREQ(NREQ), .RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = op_a[i];
            req_b[8*i +: 8] = op_b[i];
        end
    end

    typedef struct {
        int          id;
        logic [15:0] prod;
        int          rdy;
    } rsp_t;

    typedef struct {
        logic [1:0]        lane;
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic [15:0]       prod;
    } vec_t;

    rsp_t        q[$];
    int          rr;
    int          cyc;
    bit          m_issue;
    int          m_grant;
    logic [3:0]  seen_ready;
    logic        seen_rv;
    logic [1:0]  seen_id;
    logic [15:0] seen_prod;
    int          n_vec;
    int          n_err;
    vec_t        tbl [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic signed [7:0] pick();
        case ($urandom % 6)
            0:       return -8'sd128;
            1:       return 8'sd127;
            2:       return -8'sd1;
            3:       return 8'sd0;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic new_ops(input int i);
        op_a[i] = pick();
        op_b[i] = pick();
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model on the edge
    task automatic step();
        logic [3:0]  exp_ready;
        bit          exp_rv;
        int          exp_id;
        logic [15:0] exp_prod;
        bit          found;
        int          g;
        int          p;
        @(negedge clk);
        found = 0;
        g     = 0;
        if (q.size() < DEPTH) begin
            for (int k = 0; k < 4; k++) begin
                int l;
                l = (rr + k) % 4;
                if (!found && req_valid[l]) begin
                    found = 1;
                    g     = l;
                end
            end
        end
        exp_ready = found ? 4'(1 << g) : 4'd0;
        exp_rv    = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_id    = exp_rv ? q[0].id : 0;
        exp_prod  = exp_rv ? q[0].prod : 16'd0;
        seen_ready = req_ready;
        seen_rv    = rsp_valid;
        seen_id    = rsp_id;
        seen_prod  = rsp_prod;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_prod", 32'(rsp_prod), 32'(exp_prod));
        check("busy", 32'(busy), 32'(q.size() != 0));
        m_issue = found;
        m_grant = g;
        @(posedge clk);
        if (exp_rv && rsp_ready) begin
            $display("txn lane=%0d prod=%0d", q[0].id, $signed(q[0].prod));
            void'(q.pop_front());
        end
        if (found) begin
            p = int'(op_a[g]) * int'(op_b[g]);
            q.push_back('{g, 16'(p), cyc + 3});
            rr = (g + 1) % 4;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        rr = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int lane, input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!seen_ready[lane] && n < max);
        if (!seen_ready[lane]) check("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int issues;
        clk = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        rr = 0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) new_ops(i);

        // Reset state, with every lane requesting
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'h0;
        do_reset();

        // Table vectors: single lane, exact product, 3-cycle latency
        tbl[0] = '{2'd0, -8'sd128, -8'sd128, 16'sd16384};
        tbl[1] = '{2'd1, 8'sd127, -8'sd128, -16'sd16256};
        tbl[2] = '{2'd2, -8'sd1, -8'sd1, 16'sd1};
        tbl[3] = '{2'd3, 8'sd0, -8'sd128, 16'sd0};
        tbl[4] = '{2'd0, 8'sd127, 8'sd127, 16'sd16129};
        tbl[5] = '{2'd2, -8'sd128, 8'sd127, -16'sd16256};
        tbl[6] = '{2'd1, 8'sd5, -8'sd7, -16'sd35};
        rsp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            op_a[tbl[v].lane] = tbl[v].a;
            op_b[tbl[v].lane] = tbl[v].b;
            req_valid = 4'(1 << tbl[v].lane);
            wait_grant(int'(tbl[v].lane), 1);
            req_valid = 4'h0;
            lat = 0;
            do begin
                step();
                lat++;
            end while (!seen_rv && lat < 10);
            check("vec_latency", 32'(lat), 32'd3);
            check("vec_id", 32'(seen_id), 32'(tbl[v].lane));
            check("vec_prod", 32'(seen_prod), 32'(tbl[v].prod));
        end

        // All lanes valid, consumer ready: one grant per cycle in rotation
        do_reset();
        for (int i = 0; i < 4; i++) new_ops(i);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_grant", 32'(seen_ready), 32'(1 << (k % 4)));
            if (m_issue) new_ops(m_grant);
        end
        req_valid = 4'h0;
        repeat (5) step();

        // Consumer stalled: credit stops issue at FIFO depth, then drain resumes
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        issues = 0;
        repeat (8) begin
            step();
            if (seen_ready != 4'd0) issues++;
            if (m_issue) new_ops(m_grant);
        end
        check("stall_issues", 32'(issues), 32'd4);
        rsp_ready = 1'b1;
        repeat (10) begin
            step();
            if (m_issue) new_ops(m_grant);
        end
        req_valid = 4'h0;
        repeat (6) step();

        // rr_ptr at 2 with lanes 1 and 3 requesting: 3 first, lane 1 waits
        do_reset();
        new_ops(1);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        new_ops(1);
        new_ops(3);
        req_valid = 4'b1010;
        step();
        check("skip_grant3", 32'(seen_ready), 32'b1000);
        req_valid = 4'b0010;
        step();
        check("skip_grant1", 32'(seen_ready), 32'b0010);
        req_valid = 4'b0000;
        repeat (5) step();

        // Reset with work in flight and queued
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        repeat (6) begin
            step();
            if (m_issue) new_ops(m_grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_prod", 32'(rsp_prod), 32'd0);
        q.delete();
        rr = 0;
        req_valid = 4'b0110;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(seen_ready), 32'b0010);
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (6) step();

        // Random traffic against the model; requesters hold until accepted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom % 4) != 0;
            step();
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i]) begin
                    if (m_issue && m_grant == i) begin
                        if ($urandom % 2 == 0) req_valid[i] = 1'b0;
                        else new_ops(i);
                    end
                end else if ($urandom % 3 == 0) begin
                    req_valid[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
